// File: rtl/score_keeper_gen.sv
// score_keeper_gen: scorer for the binary encryption game.
// Evaluates the player's code against the RNG symbol on each load and keeps
// a saturating multi-digit BCD score, a hit streak with bonus points and a
// lives counter ending in GAME_OVER. It also drives the hit/miss LEDs.
module score_keeper_gen #(
    parameter int SYM_W      = 4,
    parameter int DIGITS     = 2,
    parameter int MAX_LIVES  = 3,
    parameter int STREAK_N   = 3,
    parameter int PENALTY_EN = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [SYM_W-1:0]      player_toggle,
    input  logic [SYM_W-1:0]      rng_op,
    input  logic                  player_ld,
    input  logic                  rng_load,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [3:0]            lives,
    output logic [3:0]            streak,
    output logic                  game_over,
    output logic                  eval_pulse,
    output logic                  ledr_out,
    output logic                  ledg_out
);

    // Three state bits so that encodings 4..7 exist and can be recovered from.
    typedef enum logic [2:0] {
        S_LOAD_WAIT    = 3'd0,
        S_SCORE_CAL    = 3'd1,
        S_WAIT_RNGLOAD = 3'd2,
        S_GAME_OVER    = 3'd3
    } state_t;

    localparam logic [4*DIGITS-1:0] SCORE_MAX  = {DIGITS{4'h9}};
    localparam logic [3:0]          LIVES_INIT = 4'(MAX_LIVES);
    localparam logic [3:0]          STREAK_LIM = 4'(STREAK_N);

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_score;
    logic [3:0]            r_lives;
    logic [3:0]            r_streak;
    logic                  r_game_over;
    logic                  r_pulse;
    logic                  r_ledr;
    logic                  r_ledg;

    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   w_score_nxt;
    logic [3:0]            w_lives_nxt;
    logic [3:0]            w_streak_nxt;
    logic                  w_pulse_nxt;
    logic                  w_ledr_nxt;
    logic                  w_ledg_nxt;

    logic                  w_hit;
    logic [3:0]            w_streak_inc;
    logic [3:0]            w_lives_dec;
    logic                  w_bonus;

    // BCD add of 1 or 2 with digit-to-digit carry; saturates at all nines.
    function automatic logic [4*DIGITS-1:0] bcd_add(
        input logic [4*DIGITS-1:0] v,
        input logic [1:0]          amt
    );
        logic [4*DIGITS-1:0] r;
        logic [4:0]          d;
        logic [4:0]          dm;
        logic [1:0]          c;
        r = v;
        c = amt;
        for (int i = 0; i < DIGITS; i++) begin
            d  = {1'b0, v[4*i +: 4]} + {3'b000, c};
            dm = d - 5'd10;
            if (d > 5'd9) begin
                r[4*i +: 4] = dm[3:0];
                c = 2'd1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 2'd0;
            end
        end
        if (c != 2'd0) begin
            r = SCORE_MAX;
        end
        return r;
    endfunction

    // BCD decrement by 1 with digit-to-digit borrow; floors at zero.
    function automatic logic [4*DIGITS-1:0] bcd_dec(
        input logic [4*DIGITS-1:0] v
    );
        logic [4*DIGITS-1:0] r;
        logic                b;
        r = v;
        b = (v != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_hit        = (player_toggle == rng_op);
    assign w_streak_inc = r_streak + 4'd1;
    assign w_lives_dec  = r_lives - 4'd1;
    assign w_bonus      = (STREAK_N != 0) && (w_streak_inc == STREAK_LIM);

    // Next-state and next-value logic for the scoring FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_streak_nxt = r_streak;
        w_pulse_nxt  = 1'b0;
        w_ledr_nxt   = r_ledr;
        w_ledg_nxt   = r_ledg;
        case (r_state)
            S_LOAD_WAIT: begin
                // player_ld wins over a concurrent rng_load here.
                if (player_ld) begin
                    w_state_nxt = S_SCORE_CAL;
                end
            end
            S_SCORE_CAL: begin
                w_pulse_nxt = 1'b1;
                if (w_hit) begin
                    w_ledg_nxt  = 1'b1;
                    w_ledr_nxt  = 1'b0;
                    w_state_nxt = S_WAIT_RNGLOAD;
                    if (w_bonus) begin
                        // Hit plus bonus is a single +2 so carries stay consistent.
                        w_score_nxt  = bcd_add(r_score, 2'd2);
                        w_streak_nxt = 4'd0;
                    end else begin
                        w_score_nxt  = bcd_add(r_score, 2'd1);
                        w_streak_nxt = w_streak_inc;
                    end
                end else begin
                    w_ledr_nxt   = 1'b1;
                    w_ledg_nxt   = 1'b0;
                    w_streak_nxt = 4'd0;
                    w_lives_nxt  = w_lives_dec;
                    if (PENALTY_EN != 0) begin
                        w_score_nxt = bcd_dec(r_score);
                    end
                    if (w_lives_dec == 4'd0) begin
                        w_state_nxt = S_GAME_OVER;
                    end else begin
                        w_state_nxt = S_LOAD_WAIT;
                    end
                end
            end
            S_WAIT_RNGLOAD: begin
                // Wait for the RNG to finish loading; a held player_ld is ignored.
                if (!rng_load) begin
                    w_state_nxt = S_LOAD_WAIT;
                end
            end
            S_GAME_OVER: begin
                // Everything frozen until reset or clear.
            end
            default: begin
                // Corrupted state register: behave as a reset.
                w_state_nxt  = S_LOAD_WAIT;
                w_score_nxt  = '0;
                w_lives_nxt  = LIVES_INIT;
                w_streak_nxt = 4'd0;
                w_ledr_nxt   = 1'b0;
                w_ledg_nxt   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset and clear share top priority.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_state     <= S_LOAD_WAIT;
            r_score     <= '0;
            r_lives     <= LIVES_INIT;
            r_streak    <= 4'd0;
            r_game_over <= 1'b0;
            r_pulse     <= 1'b0;
            r_ledr      <= 1'b0;
            r_ledg      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
            r_streak    <= w_streak_nxt;
            r_game_over <= (w_state_nxt == S_GAME_OVER);
            r_pulse     <= w_pulse_nxt;
            r_ledr      <= w_ledr_nxt;
            r_ledg      <= w_ledg_nxt;
        end
    end

    assign score_bcd  = r_score;
    assign lives      = r_lives;
    assign streak     = r_streak;
    assign game_over  = r_game_over;
    assign eval_pulse = r_pulse;
    assign ledr_out   = r_ledr;
    assign ledg_out   = r_ledg;

endmodule
